// File: rtl/fifo_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx_pkg
// Description : Shared types and helpers for the FIFO-draining UART transmitter.
//               Holds the FSM state encoding, parity mode codes and clog2.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_uart_tx_pkg;

    // Frame sequencer states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    // Parity mode codes used with the PARITY_ODD parameter
    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // Ceiling log2, clamped to at least 1 so derived vectors never collapse
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_baud_cnt
// Description : Down-counter that times one serial bit. Loaded with
//               CLKS_PER_BIT-1 at each bit start; tick marks the last cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_baud_cnt
    import fifo_uart_tx_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tick
);

    logic [WIDTH-1:0] r_count;

    // Reload on a bit start, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign tick = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : Drains words from the async FIFO read port (rclk domain) and
//               sends each as a UART frame: start, data LSB first, optional
//               parity, stop. All outputs decode registered state.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rinc,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic [7:0]            frame_count
);

    localparam int                  c_baud_w   = clog2(CLKS_PER_BIT);
    localparam int                  c_bit_w    = clog2(DATA_WIDTH + 1);
    localparam logic [c_baud_w-1:0] c_baud_top = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_bit_w-1:0]  c_last_bit = c_bit_w'(DATA_WIDTH - 1);
    localparam logic                c_par_odd  = (PARITY_ODD == PAR_ODD) ? 1'b1 : 1'b0;
    localparam logic                c_par_en   = (PARITY_EN != 0) ? 1'b1 : 1'b0;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic                  r_parity;
    logic [7:0]            r_frame_count;
    logic                  w_tick;
    logic                  w_baud_load;

    // One bit-time counter shared by the start, data, parity and stop slots
    fifo_uart_baud_cnt #(
        .WIDTH (c_baud_w)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_baud_load),
        .load_val (c_baud_top),
        .tick     (w_tick)
    );

    // State register; async reset forces IDLE so tx returns high at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, baud reload and output decode from the registered state
    always_comb begin
        w_state_nxt = r_state;
        w_baud_load = 1'b0;
        fifo_rinc   = 1'b0;
        tx          = 1'b1;
        frame_done  = 1'b0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                // FIFO flag is only looked at here, so a pop is never issued blind
                if (enable && !fifo_empty) begin
                    w_state_nxt = POP;
                end
            end
            POP: begin
                fifo_rinc   = 1'b1;
                w_state_nxt = LOAD;
            end
            LOAD: begin
                w_baud_load = 1'b1;
                w_state_nxt = START;
            end
            START: begin
                tx = 1'b0;
                if (w_tick) begin
                    w_baud_load = 1'b1;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                tx = r_shift[0];
                if (w_tick) begin
                    w_baud_load = 1'b1;
                    if (r_bit_cnt == c_last_bit) begin
                        w_state_nxt = c_par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                tx = r_parity;
                if (w_tick) begin
                    w_baud_load = 1'b1;
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                tx = 1'b1;
                if (w_tick) begin
                    frame_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Data path: capture popped word, shift per bit, count finished frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_parity      <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            case (r_state)
                LOAD: begin
                    // FIFO read data is valid the cycle after the pop strobe
                    r_shift   <= fifo_rdata;
                    r_parity  <= (^fifo_rdata) ^ c_par_odd;
                    r_bit_cnt <= '0;
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
                    end
                end
                STOP: begin
                    // Wraps 255 -> 0 silently
                    if (w_tick) begin
                        r_frame_count <= r_frame_count + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Directed self-checking bench for fifo_uart_tx with a small
//               FIFO read-port model and two extra parity configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty;
    logic [3:0] fifo_rdata = 4'h0;
    logic       fifo_rinc, tx, busy, frame_done;
    logic [7:0] frame_count;

    logic       aux_en = 1'b0;
    logic       aux_empty = 1'b1;
    logic [3:0] aux_rdata = 4'h7;
    logic       odd_rinc, odd_tx, odd_busy, odd_done;
    logic [7:0] odd_fc;
    logic       np_rinc, np_tx, np_busy, np_done;
    logic [7:0] np_fc;

    logic [3:0] mem [0:511];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int cyc = 0;
    int rinc_cnt = 0;
    int viol_cnt = 0;
    int done_cnt = 0;
    int checks = 0;
    int errors = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    fifo_uart_tx dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_rinc(fifo_rinc), .tx(tx), .busy(busy),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    fifo_uart_tx #(.PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .enable(aux_en), .fifo_empty(aux_empty),
        .fifo_rdata(aux_rdata), .fifo_rinc(odd_rinc), .tx(odd_tx), .busy(odd_busy),
        .frame_done(odd_done), .frame_count(odd_fc)
    );

    fifo_uart_tx #(.PARITY_EN(0)) dut_np (
        .clk(clk), .rst_n(rst_n), .enable(aux_en), .fifo_empty(aux_empty),
        .fifo_rdata(aux_rdata), .fifo_rinc(np_rinc), .tx(np_tx), .busy(np_busy),
        .frame_done(np_done), .frame_count(np_fc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO read-port model and event counters, sampled mid-cycle
    always @(negedge clk) begin
        if (fifo_rinc === 1'b1) begin
            rinc_cnt   <= rinc_cnt + 1;
            if (fifo_empty) viol_cnt <= viol_cnt + 1;
            fifo_rdata <= mem[rd_ptr % 512];
            rd_ptr     <= rd_ptr + 1;
        end
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [3:0] d);
        mem[wr_ptr % 512] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0;
        aux_en = 1'b0;
        aux_empty = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        wr_ptr = rd_ptr;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits for a start bit, then checks all 28 cycles of an even-parity frame
    task automatic expect_frame(input logic [3:0] d, input string name, output int start_cyc);
        logic [6:0]  bits;
        logic [27:0] got;
        logic [27:0] exp;
        int n;
        bit bad_ctl;
        start_cyc = 0;
        bits = {1'b1, ^d, d, 1'b0};
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s: no start bit within 200 clks, tx=%b", name, tx);
            return;
        end
        start_cyc = cyc;
        bad_ctl = 1'b0;
        for (int k = 0; k < 28; k++) begin
            got[k] = tx;
            exp[k] = bits[k / 4];
            if (frame_done !== ((k == 27) ? 1'b1 : 1'b0)) bad_ctl = 1'b1;
            if (busy !== 1'b1) bad_ctl = 1'b1;
            @(negedge clk);
        end
        if (busy !== 1'b0) bad_ctl = 1'b1;
        if (got !== exp || bad_ctl) begin
            errors++;
            $display("FAIL %s: tx trace %b expected %b, frame_done/busy error=%0d", name, got, exp, bad_ctl);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (fifo_rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b want 0", fifo_rinc); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", frame_count); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int r0, d0, s;
        do_reset();
        r0 = rinc_cnt;
        d0 = done_cnt;
        push(4'hA);
        enable = 1'b1;
        expect_frame(4'hA, "t1_frame_A", s);
        #1;
        checks++; if (rinc_cnt - r0 !== 1) begin errors++; $display("FAIL t1_rinc_pulses: got %0d want 1", rinc_cnt - r0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL t1_done_pulses: got %0d want 1", done_cnt - d0); end
        checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL t1_frame_count: got %0d want 1", frame_count); end
    endtask

    task automatic test_parity_modes();
        logic [6:0]  ob;
        logic [5:0]  nb;
        logic [31:0] t_odd, t_np, e_odd, e_np, b_odd, b_np, d_odd, d_np;
        int n;
        ob = 7'b1001110;   // stop, parity 0, data 0111 LSB first, start
        nb = 6'b101110;    // stop, data 0111 LSB first, start
        do_reset();
        aux_empty = 1'b0;
        aux_en = 1'b1;
        n = 0;
        while (odd_rinc !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (odd_rinc !== 1'b1 || np_rinc !== 1'b1) begin
            errors++;
            $display("FAIL t2_pop: odd_rinc=%b np_rinc=%b want both 1", odd_rinc, np_rinc);
        end
        aux_empty = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            t_odd[k] = odd_tx;  t_np[k] = np_tx;
            b_odd[k] = odd_busy; b_np[k] = np_busy;
            d_odd[k] = odd_done; d_np[k] = np_done;
            e_odd[k] = (k < 28) ? ob[k / 4] : 1'b1;
            e_np[k]  = (k < 24) ? nb[k / 4] : 1'b1;
            @(negedge clk);
        end
        checks++; if (t_odd !== e_odd) begin errors++; $display("FAIL t2_odd_trace: got %b want %b", t_odd, e_odd); end
        checks++; if (t_odd[23:20] !== 4'b0000) begin errors++; $display("FAIL t2_odd_parity_bit: got %b want 0000", t_odd[23:20]); end
        checks++; if (t_np !== e_np) begin errors++; $display("FAIL t2_noparity_trace: got %b want %b", t_np, e_np); end
        checks++; if (b_np[24:23] !== 2'b01) begin errors++; $display("FAIL t2_noparity_len: busy[24:23]=%b want 01", b_np[24:23]); end
        checks++; if (b_odd[28:27] !== 2'b01) begin errors++; $display("FAIL t2_odd_len: busy[28:27]=%b want 01", b_odd[28:27]); end
        checks++; if (d_odd !== 32'h0800_0000) begin errors++; $display("FAIL t2_odd_done: got %h want 08000000", d_odd); end
        checks++; if (d_np !== 32'h0080_0000) begin errors++; $display("FAIL t2_noparity_done: got %h want 00800000", d_np); end
        checks++; if (odd_fc !== 8'd1 || np_fc !== 8'd1) begin errors++; $display("FAIL t2_counts: odd=%0d np=%0d want 1 1", odd_fc, np_fc); end
        aux_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int r0, s1, s2, s3;
        do_reset();
        r0 = rinc_cnt;
        push(4'h1); push(4'h2); push(4'h3);
        enable = 1'b1;
        expect_frame(4'h1, "t3_frame1", s1);
        expect_frame(4'h2, "t3_frame2", s2);
        expect_frame(4'h3, "t3_frame3", s3);
        #1;
        checks++; if (s2 - s1 !== 31) begin errors++; $display("FAIL t3_gap12: start spacing %0d want 31", s2 - s1); end
        checks++; if (s3 - s2 !== 31) begin errors++; $display("FAIL t3_gap23: start spacing %0d want 31", s3 - s2); end
        checks++; if (rinc_cnt - r0 !== 3) begin errors++; $display("FAIL t3_rinc_pulses: got %0d want 3", rinc_cnt - r0); end
        checks++; if (frame_count !== 8'd3) begin errors++; $display("FAIL t3_frame_count: got %0d want 3", frame_count); end
    endtask

    task automatic test_enable_gating();
        int r0, s;
        bit bad;
        do_reset();
        r0 = rinc_cnt;
        push(4'h5); push(4'h6);
        bad = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_rinc !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL t4_disabled_idle: activity seen with enable=0, rinc=%0d want 0", rinc_cnt - r0); end
        enable = 1'b1;
        fork
            expect_frame(4'h5, "t4_frame_finishes", s);
            begin
                repeat (12) @(negedge clk);
                enable = 1'b0;
            end
        join
        bad = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (tx !== 1'b1 || fifo_rinc !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        #1;
        checks++; if (bad) begin errors++; $display("FAIL t4_hold_idle: activity after frame with enable=0"); end
        checks++; if (rinc_cnt - r0 !== 1) begin errors++; $display("FAIL t4_rinc_pulses: got %0d want 1", rinc_cnt - r0); end
        checks++; if (wr_ptr - rd_ptr !== 1) begin errors++; $display("FAIL t4_words_left: got %0d want 1", wr_ptr - rd_ptr); end
        checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL t4_frame_count: got %0d want 1", frame_count); end
    endtask

    task automatic test_reset_mid_frame();
        int s;
        do_reset();
        push(4'h3);
        enable = 1'b1;
        expect_frame(4'h3, "t5_pre_frame", s);
        push(4'h9);
        repeat (16) @(negedge clk);
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1 || frame_count !== 8'd1) begin
            errors++;
            $display("FAIL t5_mid_frame: tx=%b busy=%b count=%0d want 0 1 1", tx, busy, frame_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || frame_count !== 8'd0) begin
            errors++;
            $display("FAIL t5_async_reset: tx=%b busy=%b count=%0d want 1 0 0", tx, busy, frame_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(4'h4);
        expect_frame(4'h4, "t5_post_reset_frame", s);
        #1;
        checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL t5_frame_count: got %0d want 1", frame_count); end
    endtask

    task automatic test_counter_wrap();
        int d0, n;
        do_reset();
        d0 = done_cnt;
        for (int i = 0; i < 256; i++) push(4'(i));
        enable = 1'b1;
        n = 0;
        while (done_cnt - d0 < 255 && n < 9000) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        checks++; if (frame_count !== 8'd255) begin errors++; $display("FAIL t6_count_255: got %0d want 255 (done=%0d)", frame_count, done_cnt - d0); end
        n = 0;
        while (done_cnt - d0 < 256 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL t6_count_wrap: got %0d want 0 (done=%0d)", frame_count, done_cnt - d0); end
        checks++; if (viol_cnt !== 0) begin errors++; $display("FAIL t6_rinc_when_empty: got %0d want 0", viol_cnt); end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity_modes();
        test_back_to_back();
        test_enable_gating();
        test_reset_mid_frame();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
